cnn_job_sequencer: RTL and testbench

//  Job-level controller in front of the CNN core. Latches one job configuration, pulses CNN start,

---
 rtl/cnn_job_sequencer_if.sv | 85 ++++++++
 rtl/cnn_job_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_cnn_job_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_job_sequencer_if.sv
// Host-side and CNN-side signal bundle for the job sequencer.
// The master modport is the sequencer itself; the slave modport is the host/CNN environment.
interface cnn_job_sequencer_if #(
  parameter int unsigned IfmapBufferWidth  = 18,
  parameter int unsigned FilterBufferWidth = 16,
  parameter int unsigned ResultBufferWidth = 16,
  parameter int unsigned StrideWidth       = 5,
  parameter int unsigned FilterSizeWidth   = 5,
  parameter int unsigned CountWidth        = 8
);
  // Job configuration handshake
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [StrideWidth-1:0]       cfg_stride;
  logic [FilterSizeWidth-1:0]   cfg_filter_size;
  logic                         cfg_psum_mode;
  logic [CountWidth-1:0]        cfg_if_count;
  logic [CountWidth-1:0]        cfg_filter_count;
  logic [CountWidth-1:0]        cfg_result_count;

  // Host streams
  logic                         if_in_valid;
  logic                         if_in_ready;
  logic [IfmapBufferWidth-1:0]  if_in_data;
  logic                         flt_in_valid;
  logic                         flt_in_ready;
  logic [FilterBufferWidth-1:0] flt_in_data;
  logic                         res_out_valid;
  logic                         res_out_ready;
  logic [ResultBufferWidth-1:0] res_out_data;

  // CNN control
  logic                         start;
  logic [StrideWidth-1:0]       stride;
  logic [FilterSizeWidth-1:0]   filter_size;
  logic                         psum_mode;

  // CNN buffer ports
  logic [IfmapBufferWidth-1:0]  IFmap_buffer_in;
  logic                         IFmap_buffer_write_enable;
  logic                         IFmap_buffer_ready;
  logic [FilterBufferWidth-1:0] filter_buffer_in;
  logic                         filter_buffer_write_enable;
  logic                         filter_buffer_ready;
  logic [ResultBufferWidth-1:0] result_buffer_out;
  logic                         result_buffer_valid;
  logic                         result_buffer_empty;
  logic                         result_buffer_read_enable;

  // Job status
  logic                         busy;
  logic                         done;

  modport master (
    input  cfg_valid, cfg_stride, cfg_filter_size, cfg_psum_mode,
    input  cfg_if_count, cfg_filter_count, cfg_result_count,
    output cfg_ready,
    input  if_in_valid, if_in_data, flt_in_valid, flt_in_data, res_out_ready,
    output if_in_ready, flt_in_ready, res_out_valid, res_out_data,
    output start, stride, filter_size, psum_mode,
    output IFmap_buffer_in, IFmap_buffer_write_enable,
    input  IFmap_buffer_ready,
    output filter_buffer_in, filter_buffer_write_enable,
    input  filter_buffer_ready,
    input  result_buffer_out, result_buffer_valid, result_buffer_empty,
    output result_buffer_read_enable,
    output busy, done
  );

  modport slave (
    output cfg_valid, cfg_stride, cfg_filter_size, cfg_psum_mode,
    output cfg_if_count, cfg_filter_count, cfg_result_count,
    input  cfg_ready,
    output if_in_valid, if_in_data, flt_in_valid, flt_in_data, res_out_ready,
    input  if_in_ready, flt_in_ready, res_out_valid, res_out_data,
    input  start, stride, filter_size, psum_mode,
    input  IFmap_buffer_in, IFmap_buffer_write_enable,
    output IFmap_buffer_ready,
    input  filter_buffer_in, filter_buffer_write_enable,
    output filter_buffer_ready,
    output result_buffer_out, result_buffer_valid, result_buffer_empty,
    input  result_buffer_read_enable,
    input  busy, done
  );
endinterface

// File: rtl/cnn_job_sequencer.sv
// Job-level controller for the CNN core: accepts one job config, pulses start, moves IFmap and
// filter words into the CNN buffers through one-entry holding registers, drains a fixed number
// of results to the host, then pulses done.
module cnn_job_sequencer #(
  parameter int unsigned IfmapBufferWidth  = 18,
  parameter int unsigned FilterBufferWidth = 16,
  parameter int unsigned ResultBufferWidth = 16,
  parameter int unsigned StrideWidth       = 5,
  parameter int unsigned FilterSizeWidth   = 5,
  parameter int unsigned CountWidth        = 8
) (
  input logic                 clk,
  input logic                 reset,
  cnn_job_sequencer_if.master bus
);
  localparam logic [CountWidth-1:0] CntOne = CountWidth'(1);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Latched job configuration
  logic [StrideWidth-1:0]     stride_q, stride_d;
  logic [FilterSizeWidth-1:0] fsize_q, fsize_d;
  logic                       psum_q, psum_d;
  logic [CountWidth-1:0]      if_count_q, if_count_d;
  logic [CountWidth-1:0]      flt_count_q, flt_count_d;
  logic [CountWidth-1:0]      res_count_q, res_count_d;

  // IFmap write engine
  logic                        if_full_q, if_full_d;
  logic [IfmapBufferWidth-1:0] if_data_q, if_data_d;
  logic [CountWidth-1:0]       if_cnt_q, if_cnt_d;

  // Filter write engine
  logic                         flt_full_q, flt_full_d;
  logic [FilterBufferWidth-1:0] flt_data_q, flt_data_d;
  logic [CountWidth-1:0]        flt_cnt_q, flt_cnt_d;

  // Result drain engine
  logic                         rd_pend_q, rd_pend_d;
  logic                         res_full_q, res_full_d;
  logic [ResultBufferWidth-1:0] res_data_q, res_data_d;
  logic [CountWidth-1:0]        res_cnt_q, res_cnt_d;

  logic run, cfg_accept;
  logic if_accept, if_complete, if_done;
  logic flt_accept, flt_complete, flt_done;
  logic rd_req, rd_capture, res_pop, drain_done;

  // Handshakes, engine status and all bus outputs
  always_comb begin
    run        = (state_q == StRun);
    cfg_accept = (state_q == StIdle) && bus.cfg_valid;

    bus.cfg_ready   = (state_q == StIdle);
    bus.start       = (state_q == StStart);
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StDone);
    bus.stride      = stride_q;
    bus.filter_size = fsize_q;
    bus.psum_mode   = psum_q;

    // Ready only with an empty holding reg, so accept and write completion never share a cycle
    bus.if_in_ready               = run && !if_full_q && (if_cnt_q < if_count_q);
    if_accept                     = bus.if_in_valid && bus.if_in_ready;
    bus.IFmap_buffer_write_enable = if_full_q;
    bus.IFmap_buffer_in           = if_data_q;
    if_complete                   = if_full_q && bus.IFmap_buffer_ready;
    if_done                       = !if_full_q && (if_cnt_q >= if_count_q);

    bus.flt_in_ready               = run && !flt_full_q && (flt_cnt_q < flt_count_q);
    flt_accept                     = bus.flt_in_valid && bus.flt_in_ready;
    bus.filter_buffer_write_enable = flt_full_q;
    bus.filter_buffer_in           = flt_data_q;
    flt_complete                   = flt_full_q && bus.filter_buffer_ready;
    flt_done                       = !flt_full_q && (flt_cnt_q >= flt_count_q);

    // A read in flight stays asserted even if the CNN reports empty before answering
    rd_req = run && !res_full_q && (res_cnt_q < res_count_q) &&
             (rd_pend_q || !bus.result_buffer_empty);
    rd_capture                    = rd_req && bus.result_buffer_valid;
    bus.result_buffer_read_enable = rd_req;
    bus.res_out_valid             = res_full_q;
    bus.res_out_data              = res_data_q;
    res_pop                       = res_full_q && bus.res_out_ready;
    drain_done                    = !res_full_q && (res_cnt_q >= res_count_q);
  end

  // Job FSM and configuration latch
  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    fsize_d     = fsize_q;
    psum_d      = psum_q;
    if_count_d  = if_count_q;
    flt_count_d = flt_count_q;
    res_count_d = res_count_q;
    case (state_q)
      StIdle: begin
        if (cfg_accept) begin
          stride_d    = bus.cfg_stride;
          fsize_d     = bus.cfg_filter_size;
          psum_d      = bus.cfg_psum_mode;
          if_count_d  = bus.cfg_if_count;
          flt_count_d = bus.cfg_filter_count;
          res_count_d = bus.cfg_result_count;
          state_d     = StStart;
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        if (if_done && flt_done && drain_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // IFmap engine: hold one word until the buffer takes it
  always_comb begin
    if_full_d = if_full_q;
    if_data_d = if_data_q;
    if_cnt_d  = if_cnt_q;
    if (cfg_accept) begin
      if_full_d = 1'b0;
      if_cnt_d  = '0;
    end else begin
      if (if_complete) begin
        if_full_d = 1'b0;
        if (if_cnt_q < if_count_q) if_cnt_d = if_cnt_q + CntOne;
      end
      if (if_accept) begin
        if_full_d = 1'b1;
        if_data_d = bus.if_in_data;
      end
    end
  end

  // Filter engine: same structure as the IFmap engine
  always_comb begin
    flt_full_d = flt_full_q;
    flt_data_d = flt_data_q;
    flt_cnt_d  = flt_cnt_q;
    if (cfg_accept) begin
      flt_full_d = 1'b0;
      flt_cnt_d  = '0;
    end else begin
      if (flt_complete) begin
        flt_full_d = 1'b0;
        if (flt_cnt_q < flt_count_q) flt_cnt_d = flt_cnt_q + CntOne;
      end
      if (flt_accept) begin
        flt_full_d = 1'b1;
        flt_data_d = bus.flt_in_data;
      end
    end
  end

  // Drain engine: one outstanding read, one-entry output register
  always_comb begin
    rd_pend_d  = rd_pend_q;
    res_full_d = res_full_q;
    res_data_d = res_data_q;
    res_cnt_d  = res_cnt_q;
    if (cfg_accept) begin
      rd_pend_d  = 1'b0;
      res_full_d = 1'b0;
      res_cnt_d  = '0;
    end else begin
      rd_pend_d = rd_req && !bus.result_buffer_valid;
      if (res_pop) res_full_d = 1'b0;
      if (rd_capture) begin
        res_full_d = 1'b1;
        res_data_d = bus.result_buffer_out;
        if (res_cnt_q < res_count_q) res_cnt_d = res_cnt_q + CntOne;
      end
    end
  end

  // State registers; reset aborts any job and drops held words
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      stride_q    <= '0;
      fsize_q     <= '0;
      psum_q      <= 1'b0;
      if_count_q  <= '0;
      flt_count_q <= '0;
      res_count_q <= '0;
      if_full_q   <= 1'b0;
      if_data_q   <= '0;
      if_cnt_q    <= '0;
      flt_full_q  <= 1'b0;
      flt_data_q  <= '0;
      flt_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      res_full_q  <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      fsize_q     <= fsize_d;
      psum_q      <= psum_d;
      if_count_q  <= if_count_d;
      flt_count_q <= flt_count_d;
      res_count_q <= res_count_d;
      if_full_q   <= if_full_d;
      if_data_q   <= if_data_d;
      if_cnt_q    <= if_cnt_d;
      flt_full_q  <= flt_full_d;
      flt_data_q  <= flt_data_d;
      flt_cnt_q   <= flt_cnt_d;
      rd_pend_q   <= rd_pend_d;
      res_full_q  <= res_full_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_cnn_job_sequencer.sv
// Directed bench for cnn_job_sequencer with scoreboard queues for IFmap, filter and result words.
`timescale 1ns/1ps
module tb_cnn_job_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_job_sequencer_if bus ();

  cnn_job_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int if_acc_n = 0, if_wr_n = 0, flt_acc_n = 0, flt_wr_n = 0, res_out_n = 0, done_n = 0;
  int b_if_acc, b_if_wr, b_flt_acc, b_flt_wr, b_res, b_done;
  int if_k, flt_k, res_k;
  logic if_fire = 1'b0, flt_fire = 1'b0, rd_seen = 1'b0, res_cap = 1'b0;
  logic found;
  logic [31:0] if_q[$];
  logic [31:0] flt_q[$];
  logic [31:0] res_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: handshakes seen at the negedge take effect at the following posedge
  initial begin
    forever begin
      @(negedge clk);
      if_fire  = 1'b0;
      flt_fire = 1'b0;
      rd_seen  = 1'b0;
      res_cap  = 1'b0;
      if (reset) begin
        if_fire = bus.if_in_valid && bus.if_in_ready;
        if (if_fire) begin
          if_q.push_back(32'(bus.if_in_data));
          if_acc_n++;
        end
        if (bus.IFmap_buffer_write_enable) begin
          chk("if_ready_while_holding", 32'(bus.if_in_ready), 32'd0);
          if (bus.IFmap_buffer_ready) begin
            chk("if_write_has_expected", 32'(if_q.size() != 0), 32'd1);
            if (if_q.size() != 0) chk("if_write_data", 32'(bus.IFmap_buffer_in), if_q.pop_front());
            if_wr_n++;
          end
        end
        flt_fire = bus.flt_in_valid && bus.flt_in_ready;
        if (flt_fire) begin
          flt_q.push_back(32'(bus.flt_in_data));
          flt_acc_n++;
        end
        if (bus.filter_buffer_write_enable) begin
          chk("flt_ready_while_holding", 32'(bus.flt_in_ready), 32'd0);
          if (bus.filter_buffer_ready) begin
            chk("flt_write_has_expected", 32'(flt_q.size() != 0), 32'd1);
            if (flt_q.size() != 0)
              chk("flt_write_data", 32'(bus.filter_buffer_in), flt_q.pop_front());
            flt_wr_n++;
          end
        end
        rd_seen = bus.result_buffer_read_enable;
        res_cap = bus.result_buffer_read_enable && bus.result_buffer_valid;
        if (res_cap) res_q.push_back(32'(bus.result_buffer_out));
        if (bus.res_out_valid) begin
          chk("read_while_out_full", 32'(bus.result_buffer_read_enable), 32'd0);
          if (bus.res_out_ready) begin
            chk("res_has_expected", 32'(res_q.size() != 0), 32'd1);
            if (res_q.size() != 0) chk("res_out_data", 32'(bus.res_out_data), res_q.pop_front());
            res_out_n++;
          end
        end
        if (bus.done) done_n++;
      end
    end
  end

  // Host IFmap source, always valid
  initial begin
    if_k = 0;
    bus.if_in_valid = 1'b0;
    bus.if_in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) if_k = 0;
      else if (if_fire) if_k++;
      bus.if_in_valid = 1'b1;
      bus.if_in_data  = 18'h10000 + 18'(if_k * 5 + 1);
    end
  end

  // Host filter source, always valid
  initial begin
    flt_k = 0;
    bus.flt_in_valid = 1'b0;
    bus.flt_in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) flt_k = 0;
      else if (flt_fire) flt_k++;
      bus.flt_in_valid = 1'b1;
      bus.flt_in_data  = 16'hF000 + 16'(flt_k * 7);
    end
  end

  // CNN result buffer model: answers a read one cycle after it is raised
  initial begin
    res_k = 0;
    bus.result_buffer_valid = 1'b0;
    bus.result_buffer_out   = '0;
    bus.result_buffer_empty = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        res_k = 0;
        bus.result_buffer_valid = 1'b0;
      end else if (res_cap) begin
        res_k++;
        bus.result_buffer_valid = 1'b0;
      end else if (rd_seen) begin
        bus.result_buffer_valid = 1'b1;
        bus.result_buffer_out   = 16'hA000 + 16'(res_k * 3);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_idle(input string tag);
    chk({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_start"}, 32'(bus.start), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_if_ready"}, 32'(bus.if_in_ready), 32'd0);
    chk({tag, "_flt_ready"}, 32'(bus.flt_in_ready), 32'd0);
    chk({tag, "_if_we"}, 32'(bus.IFmap_buffer_write_enable), 32'd0);
    chk({tag, "_flt_we"}, 32'(bus.filter_buffer_write_enable), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.result_buffer_read_enable), 32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_out_valid), 32'd0);
    chk({tag, "_stride"}, 32'(bus.stride), 32'd0);
    chk({tag, "_if_data"}, 32'(bus.IFmap_buffer_in), 32'd0);
  endtask

  task automatic start_job(input int s, input int fsz, input int psum,
                           input int ic, input int fc, input int rc);
    @(posedge clk); #2;
    b_if_acc  = if_acc_n;
    b_if_wr   = if_wr_n;
    b_flt_acc = flt_acc_n;
    b_flt_wr  = flt_wr_n;
    b_res     = res_out_n;
    b_done    = done_n;
    bus.cfg_stride       = 5'(s);
    bus.cfg_filter_size  = 5'(fsz);
    bus.cfg_psum_mode    = 1'(psum);
    bus.cfg_if_count     = 8'(ic);
    bus.cfg_filter_count = 8'(fc);
    bus.cfg_result_count = 8'(rc);
    bus.cfg_valid        = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.cfg_ready) found = 1'b1;
    end
    chk("cfg_accepted", 32'(found), 32'd1);
    @(posedge clk); #2;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("start_pulse", 32'(bus.start), 32'd1);
    chk("busy_in_start", 32'(bus.busy), 32'd1);
    chk("stride_out", 32'(bus.stride), 32'(s));
    chk("filter_size_out", 32'(bus.filter_size), 32'(fsz));
    chk("psum_mode_out", 32'(bus.psum_mode), 32'(psum));
    @(negedge clk);
    chk("start_one_cycle", 32'(bus.start), 32'd0);
    chk("busy_in_run", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input int maxc);
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (bus.done) found = 1'b1;
    end
    chk("done_seen", 32'(found), 32'd1);
    chk("busy_with_done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("cfg_ready_after_done", 32'(bus.cfg_ready), 32'd1);
  endtask

  task automatic check_job(input int ic, input int fc, input int rc);
    chk("if_accepts", 32'(if_acc_n - b_if_acc), 32'(ic));
    chk("if_writes", 32'(if_wr_n - b_if_wr), 32'(ic));
    chk("flt_accepts", 32'(flt_acc_n - b_flt_acc), 32'(fc));
    chk("flt_writes", 32'(flt_wr_n - b_flt_wr), 32'(fc));
    chk("res_outputs", 32'(res_out_n - b_res), 32'(rc));
    chk("done_pulses", 32'(done_n - b_done), 32'd1);
    chk("if_queue_empty", 32'(if_q.size()), 32'd0);
    chk("flt_queue_empty", 32'(flt_q.size()), 32'd0);
    chk("res_queue_empty", 32'(res_q.size()), 32'd0);
  endtask

  initial begin
    reset                   = 1'b0;
    bus.cfg_valid           = 1'b0;
    bus.cfg_stride          = '0;
    bus.cfg_filter_size     = '0;
    bus.cfg_psum_mode       = 1'b0;
    bus.cfg_if_count        = '0;
    bus.cfg_filter_count    = '0;
    bus.cfg_result_count    = '0;
    bus.IFmap_buffer_ready  = 1'b1;
    bus.filter_buffer_ready = 1'b1;
    bus.res_out_ready       = 1'b1;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #2;
    reset = 1'b1;

    // Full job, free-flowing streams
    start_job(4, 4, 0, 16, 16, 4);
    wait_done(400);
    check_job(16, 16, 4);

    // IFmap buffer stall and host result back-pressure
    @(posedge clk); #2;
    bus.IFmap_buffer_ready = 1'b0;
    bus.res_out_ready      = 1'b0;
    start_job(2, 3, 1, 4, 4, 2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.IFmap_buffer_write_enable) found = 1'b1;
      else @(negedge clk);
    end
    chk("if_we_seen", 32'(found), 32'd1);
    for (int i = 0; i < 7; i++) begin
      chk("stall_if_we_held", 32'(bus.IFmap_buffer_write_enable), 32'd1);
      chk("stall_if_pending", 32'(if_q.size()), 32'd1);
      chk("stall_if_data", 32'(bus.IFmap_buffer_in), if_q[0]);
      chk("stall_if_no_accept", 32'(bus.if_in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #2;
    bus.IFmap_buffer_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.res_out_valid) found = 1'b1;
    end
    chk("res_valid_seen", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid_held", 32'(bus.res_out_valid), 32'd1);
      chk("bp_no_read", 32'(bus.result_buffer_read_enable), 32'd0);
      chk("bp_res_data", 32'(bus.res_out_data), res_q[0]);
      @(negedge clk);
    end
    @(posedge clk); #2;
    bus.res_out_ready = 1'b1;
    wait_done(400);
    check_job(4, 4, 2);

    // Zero IFmap count
    start_job(1, 1, 0, 0, 2, 1);
    wait_done(200);
    check_job(0, 2, 1);

    // Reset in the middle of a job
    start_job(4, 4, 0, 16, 16, 4);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (if_wr_n - b_if_wr >= 5) found = 1'b1;
    end
    chk("five_if_writes", 32'(found), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    if_q.delete();
    flt_q.delete();
    res_q.delete();
    @(negedge clk);
    check_idle("midjob_reset");
    chk("no_done_on_abort", 32'(done_n - b_done), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;

    // Clean job after abort
    start_job(3, 2, 1, 3, 3, 2);
    wait_done(200);
    check_job(3, 3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
